// File: rtl/mano_pkg.sv
// mano_pkg: shared constants and enums for the Mano basic-computer control unit.
package mano_pkg;
    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_TR   = 3'd6;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    typedef enum logic [3:0] {
        ALU_NOP, ALU_AND, ALU_ADD, ALU_PASS_DR, ALU_CMA, ALU_CIR, ALU_CIL, ALU_CLE, ALU_CME
    } alu_op_e;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    localparam int B_CLA = 11;
    localparam int B_CLE = 10;
    localparam int B_CMA = 9;
    localparam int B_CME = 8;
    localparam int B_CIR = 7;
    localparam int B_CIL = 6;
    localparam int B_INC = 5;
    localparam int B_SPA = 4;
    localparam int B_SNA = 3;
    localparam int B_SZA = 2;
    localparam int B_SZE = 1;
    localparam int B_HLT = 0;
endpackage

// File: rtl/mano_seq_counter.sv
// mano_seq_counter: 4-bit timing sequence counter with clear, increment and hold.
module mano_seq_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [3:0] count_o
);
    logic [3:0] count_q, count_d;
    always_comb count_d = clr_i ? 4'd0 : inc_i ? count_q + 4'd1 : count_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) count_q <= 4'd0;
        else count_q <= count_d;
    assign count_o = count_q;
endmodule

// File: rtl/mano_control_unit.sv
// mano_control_unit: timing-state decode of the Mano basic computer, driving bus,
// register strobes, memory requests and ALU op from SC, IR, the I flag and status.
module mano_control_unit
    import mano_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        ac_sign,
    input  logic        ac_zero,
    input  logic        e_bit,
    input  logic        dr_zero,
    input  logic        mem_ready,
    output logic [2:0]  bus_sel,
    output logic        ld_ar, inc_ar, clr_ar,
    output logic        ld_pc, inc_pc, clr_pc,
    output logic        ld_dr, inc_dr, clr_dr,
    output logic        ld_ac, inc_ac, clr_ac,
    output logic        ld_ir, inc_ir, clr_ir,
    output logic        ld_tr, inc_tr, clr_tr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [3:0]  alu_op,
    output logic [3:0]  t_state,
    output logic        halted
);
    localparam int R_AR = 0, R_PC = 1, R_DR = 2, R_AC = 3, R_IR = 4, R_TR = 5;

    logic [3:0] sc;
    logic [2:0] op, bus;
    logic [5:0] ld, inc, clr, ld_g, inc_g, clr_g;
    logic       rd, wr, sc_clr, latch_i, set_halt, stall, en, quiet;
    logic       i_q, i_d, halted_q, halted_d;
    alu_op_e    alu;

    assign op = ir[14:12];

    always_comb begin
        bus = BUS_NONE;
        rd = 1'b0;
        wr = 1'b0;
        alu = ALU_NOP;
        ld = '0;
        inc = '0;
        clr = '0;
        sc_clr = 1'b0;
        latch_i = 1'b0;
        set_halt = 1'b0;
        case (sc)
            4'd0: begin bus = BUS_PC; ld[R_AR] = 1'b1; end
            4'd1: begin bus = BUS_MEM; rd = 1'b1; ld[R_IR] = 1'b1; inc[R_PC] = 1'b1; end
            4'd2: begin bus = BUS_IR; ld[R_AR] = 1'b1; latch_i = 1'b1; end
            4'd3:
                if (op == OP_REG) begin
                    sc_clr = 1'b1;
                    // highest-numbered set bit wins; I/O (I=1) is a NOP
                    if (!i_q) begin
                        if (ir[B_CLA]) clr[R_AC] = 1'b1;
                        else if (ir[B_CLE]) alu = ALU_CLE;
                        else if (ir[B_CMA]) begin alu = ALU_CMA; ld[R_AC] = 1'b1; end
                        else if (ir[B_CME]) alu = ALU_CME;
                        else if (ir[B_CIR]) begin alu = ALU_CIR; ld[R_AC] = 1'b1; end
                        else if (ir[B_CIL]) begin alu = ALU_CIL; ld[R_AC] = 1'b1; end
                        else if (ir[B_INC]) inc[R_AC] = 1'b1;
                        else if (ir[B_SPA]) inc[R_PC] = ~ac_sign;
                        else if (ir[B_SNA]) inc[R_PC] = ac_sign;
                        else if (ir[B_SZA]) inc[R_PC] = ac_zero;
                        else if (ir[B_SZE]) inc[R_PC] = ~e_bit;
                        else if (ir[B_HLT]) set_halt = 1'b1;
                    end
                end else if (i_q) begin
                    bus = BUS_MEM; rd = 1'b1; ld[R_AR] = 1'b1;
                end
            4'd4:
                case (op)
                    OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin bus = BUS_MEM; rd = 1'b1; ld[R_DR] = 1'b1; end
                    OP_STA: begin bus = BUS_AC; wr = 1'b1; sc_clr = 1'b1; end
                    OP_BUN: begin bus = BUS_AR; ld[R_PC] = 1'b1; sc_clr = 1'b1; end
                    OP_BSA: begin bus = BUS_PC; wr = 1'b1; inc[R_AR] = 1'b1; end
                    default: sc_clr = 1'b1;
                endcase
            4'd5:
                case (op)
                    OP_AND, OP_ADD, OP_LDA: begin
                        alu = op == OP_AND ? ALU_AND : op == OP_ADD ? ALU_ADD : ALU_PASS_DR;
                        ld[R_AC] = 1'b1;
                        sc_clr = 1'b1;
                    end
                    OP_BSA: begin bus = BUS_AR; ld[R_PC] = 1'b1; sc_clr = 1'b1; end
                    OP_ISZ: inc[R_DR] = 1'b1;
                    default: sc_clr = 1'b1;
                endcase
            4'd6: begin
                sc_clr = 1'b1;
                if (op == OP_ISZ) begin bus = BUS_DR; wr = 1'b1; inc[R_PC] = dr_zero; end
            end
            default: sc_clr = 1'b1;
        endcase
    end

    // a pending memory access freezes SC, so bus/rd/wr/alu decode holds by itself
    assign stall = (rd | wr) & ~mem_ready;
    assign quiet = reset | halted_q;
    assign en    = ~stall & ~quiet;
    assign ld_g  = en ? ld : '0;
    assign inc_g = en ? inc : '0;
    assign clr_g = en ? clr : '0;

    always_comb begin
        i_d = en && latch_i ? ir[15] : i_q;
        halted_d = halted_q | (en & set_halt);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            i_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            i_q <= i_d;
            halted_q <= halted_d;
        end

    mano_seq_counter u_sc (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (en),
        .clr_i   (en & sc_clr),
        .count_o (sc)
    );

    assign bus_sel = quiet ? BUS_NONE : bus;
    assign mem_rd  = rd & ~quiet;
    assign mem_wr  = wr & ~quiet;
    assign alu_op  = quiet ? ALU_NOP : alu;
    assign t_state = sc;
    assign halted  = halted_q;
    assign {ld_tr, ld_ir, ld_ac, ld_dr, ld_pc, ld_ar} = ld_g;
    assign {inc_tr, inc_ir, inc_ac, inc_dr, inc_pc, inc_ar} = inc_g;
    assign {clr_tr, clr_ir, clr_ac, clr_dr, clr_pc, clr_ar} = clr_g;
endmodule

// File: tb/tb_mano_control_unit.sv
// tb_mano_control_unit: table-driven per-cycle checks of the control unit plus
// hand-written stall and mid-instruction reset sequences.
module tb_mano_control_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic [15:0] ir = '0;
    logic        ac_sign = 0, ac_zero = 0, e_bit = 0, dr_zero = 0, mem_ready = 1;
    logic [2:0]  bus_sel;
    logic        ld_ar, inc_ar, clr_ar, ld_pc, inc_pc, clr_pc, ld_dr, inc_dr, clr_dr;
    logic        ld_ac, inc_ac, clr_ac, ld_ir, inc_ir, clr_ir, ld_tr, inc_tr, clr_tr;
    logic        mem_rd, mem_wr, halted;
    logic [3:0]  alu_op, t_state;
    logic [5:0]  ldv, incv, clrv;
    int          total = 0, bad = 0;

    typedef struct {
        logic        rst;
        logic [15:0] ir;
        logic [3:0]  st;
        logic        rdy;
        logic [31:0] exp;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    mano_control_unit dut (
        .clk(clk), .reset(reset), .ir(ir), .ac_sign(ac_sign), .ac_zero(ac_zero),
        .e_bit(e_bit), .dr_zero(dr_zero), .mem_ready(mem_ready), .bus_sel(bus_sel),
        .ld_ar(ld_ar), .inc_ar(inc_ar), .clr_ar(clr_ar), .ld_pc(ld_pc), .inc_pc(inc_pc), .clr_pc(clr_pc),
        .ld_dr(ld_dr), .inc_dr(inc_dr), .clr_dr(clr_dr), .ld_ac(ld_ac), .inc_ac(inc_ac), .clr_ac(clr_ac),
        .ld_ir(ld_ir), .inc_ir(inc_ir), .clr_ir(clr_ir), .ld_tr(ld_tr), .inc_tr(inc_tr), .clr_tr(clr_tr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_op(alu_op), .t_state(t_state), .halted(halted)
    );

    assign ldv  = {ld_tr, ld_ir, ld_ac, ld_dr, ld_pc, ld_ar};
    assign incv = {inc_tr, inc_ir, inc_ac, inc_dr, inc_pc, inc_ar};
    assign clrv = {clr_tr, clr_ir, clr_ac, clr_dr, clr_pc, clr_ar};

    function automatic logic [31:0] act();
        return {t_state, bus_sel, mem_rd, mem_wr, alu_op, ldv, incv, clrv, halted};
    endfunction

    function automatic logic [31:0] pk(int t, int b, int rw, int a, int l, int n, int c, int h);
        logic [31:0] x;
        x = {t[3:0], b[2:0], rw[1:0], a[3:0], l[5:0], n[5:0], c[5:0], h[0]};
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    // st = {ac_sign, ac_zero, e_bit, dr_zero}; rw = {rd, wr}; strobe bits = {tr,ir,ac,dr,pc,ar}
    task automatic add(input int r, input int i, input int s, input int y, input int t,
                       input int b, input int rw, input int a, input int l, input int n,
                       input int c, input int h);
        vec_t x;
        x.rst = r[0];
        x.ir = i[15:0];
        x.st = s[3:0];
        x.rdy = y[0];
        x.exp = pk(t, b, rw, a, l, n, c, h);
        tv.push_back(x);
    endtask

    task automatic fetch(input int r, input int i, input int s);
        add(r, i, s, 1, 0, 2, 0, 0, 'h01, 0, 0, 0);
        add(0, i, s, 1, 1, 7, 2, 0, 'h10, 'h02, 0, 0);
        add(0, i, s, 1, 2, 5, 0, 0, 'h01, 0, 0, 0);
    endtask

    task automatic regref(input int i, input int s, input int a, input int l, input int n, input int c);
        fetch(0, i, s);
        add(0, i, s, 1, 3, 0, 0, a, l, n, c, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("in_reset", act(), 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        fetch(1, 'h2005, 0);
        add(0, 'h2005, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h2005, 0, 1, 4, 7, 2, 0, 'h04, 0, 0, 0);
        add(0, 'h2005, 0, 1, 5, 0, 0, 3, 'h08, 0, 0, 0);
        fetch(0, 'hB00A, 0);
        add(0, 'hB00A, 0, 1, 3, 7, 2, 0, 'h01, 0, 0, 0);
        add(0, 'hB00A, 0, 0, 4, 4, 1, 0, 0, 0, 0, 0);
        add(0, 'hB00A, 0, 0, 4, 4, 1, 0, 0, 0, 0, 0);
        add(0, 'hB00A, 0, 1, 4, 4, 1, 0, 0, 0, 0, 0);
        for (int z = 1; z >= 0; z--) begin
            fetch(0, 'h6010, z);
            add(0, 'h6010, z, 1, 3, 0, 0, 0, 0, 0, 0, 0);
            add(0, 'h6010, z, 1, 4, 7, 2, 0, 'h04, 0, 0, 0);
            add(0, 'h6010, z, 1, 5, 0, 0, 0, 0, 'h04, 0, 0);
            add(0, 'h6010, z, 1, 6, 3, 1, 0, 0, z * 2, 0, 0);
        end
        fetch(0, 'h5123, 0);
        add(0, 'h5123, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h5123, 0, 1, 4, 2, 1, 0, 0, 'h01, 0, 0);
        add(0, 'h5123, 0, 1, 5, 1, 0, 0, 'h02, 0, 0, 0);
        fetch(0, 'h4123, 0);
        add(0, 'h4123, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h4123, 0, 1, 4, 1, 0, 0, 'h02, 0, 0, 0);
        fetch(0, 'h1040, 0);
        add(0, 'h1040, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h1040, 0, 1, 4, 7, 2, 0, 'h04, 0, 0, 0);
        add(0, 'h1040, 0, 1, 5, 0, 0, 2, 'h08, 0, 0, 0);
        regref('h7004, 'b0100, 0, 0, 'h02, 0);
        regref('h7004, 'b0000, 0, 0, 0, 0);
        regref('h7800, 0, 0, 0, 0, 'h08);
        regref('h7200, 0, 4, 'h08, 0, 0);
        regref('h7880, 0, 0, 0, 0, 'h08);
        regref('h7040, 0, 6, 'h08, 0, 0);
        regref('h7008, 'b1000, 0, 0, 'h02, 0);
        regref('h7010, 'b1000, 0, 0, 0, 0);
        regref('h7002, 'b0000, 0, 0, 'h02, 0);
        regref('h7002, 'b0010, 0, 0, 0, 0);
        regref('h7100, 0, 8, 0, 0, 0);
        regref('h7020, 0, 0, 0, 'h08, 0);
        regref('h7000, 0, 0, 0, 0, 0);
        regref('hF0FF, 0, 0, 0, 0, 0);
        regref('h7001, 0, 0, 0, 0, 0);
        add(0, 'h7001, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 'h2005, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        fetch(1, 'h3000, 0);

        for (int k = 0; k < tv.size(); k++) begin
            if (tv[k].rst) do_reset();
            ir = tv[k].ir;
            {ac_sign, ac_zero, e_bit, dr_zero} = tv[k].st;
            mem_ready = tv[k].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_ir%h", k, tv[k].ir), act(), tv[k].exp);
            @(posedge clk);
            #1;
        end

        do_reset();
        ir = 16'h2005;
        {ac_sign, ac_zero, e_bit, dr_zero} = 4'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_t1", act(), pk(1, 7, 2, 0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("stall_release", act(), pk(1, 7, 2, 0, 'h10, 'h02, 0, 0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("after_stall_t2", act(), pk(2, 5, 0, 0, 'h01, 0, 0, 0));

        do_reset();
        ir = 16'h1005;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("add_t5", act(), pk(5, 0, 0, 2, 'h08, 0, 0, 0));
        #1 reset = 1'b1;
        #1 chk("reset_mid_add", act(), 32'h0);
        @(posedge clk);
        #1 chk("reset_held", act(), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("restart_t0", act(), pk(0, 2, 0, 0, 'h01, 0, 0, 0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("restart_t1", act(), pk(1, 7, 2, 0, 'h10, 'h02, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
